udma_ch_alloc: RTL and testbench

- Run-time allocator for uDMA linear channels.
- Assigns free physical channel IDs from a parametrised pool to requesting peripherals, replacing the fixed compile-time channel map.
- Each requester holds at most one channel until it releases it.
- Sits between the peripheral wrappers and the uDMA core channel muxes; the granted ID drives the mux selects.

---
 rtl/udma_ch_alloc.sv | 146 ++++++++++++++
 tb/tb_udma_ch_alloc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/udma_ch_alloc.sv
// udma_ch_alloc: run-time allocator for uDMA linear channels.
// Hands out free physical channel IDs from a pool of N_CH channels to up to
// N_REQ requesting peripherals. Each requester owns at most one channel at a
// time. Requesters are arbitrated round-robin and always receive the
// lowest-index free channel.
//
// Ports:
//   clk_i      - system clock
//   rstn_i     - asynchronous active-low reset
//   clr_i      - synchronous flush of all allocations
//   req_i      - per-requester allocation request (level, held until grant)
//   rel_i      - per-requester release (one-cycle pulse)
//   grant_o    - one-cycle grant pulse per requester
//   alloc_o    - requester currently owns a channel
//   ch_id_o    - packed owned channel ID per requester (qualify with alloc_o)
//   ch_busy_o  - per-channel ownership bitmap
//   free_cnt_o - number of free channels
//   full_o     - no free channel left
module udma_ch_alloc #(
  parameter int N_CH  = 8,
  parameter int N_REQ = 12,
  parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int CNT_W = $clog2(N_CH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        rel_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        alloc_o,
  output logic [N_REQ*ID_W-1:0]   ch_id_o,
  output logic [N_CH-1:0]         ch_busy_o,
  output logic [CNT_W-1:0]        free_cnt_o,
  output logic                    full_o
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_CH-1:0]       busy_q, busy_d;
  logic [N_REQ-1:0]      alloc_q, alloc_d;
  logic [N_REQ*ID_W-1:0] id_q, id_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [RR_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;

  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      rel_vld;
  logic                  ch_free;
  logic [ID_W-1:0]       ch_sel;
  logic                  win_vld;
  logic [RR_W-1:0]       win;
  logic                  do_grant;
  logic [CNT_W-1:0]      rel_cnt;
  int unsigned           idx;

  always_comb begin
    rel_vld = rel_i & alloc_q;
    // A requester releasing this cycle may not also be granted.
    elig    = req_i & ~alloc_q & ~rel_i;

    // Lowest-index free channel, judged on the registered bitmap only, so a
    // channel freed this cycle becomes grantable one cycle later.
    ch_free = 1'b0;
    ch_sel  = '0;
    for (int unsigned c = N_CH; c > 0; c--) begin
      if (!busy_q[c-1]) begin
        ch_free = 1'b1;
        ch_sel  = ID_W'(c - 1);
      end
    end

    // First eligible requester at or above the RR pointer, wrapping.
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int unsigned i = 0; i < unsigned'(N_REQ); i++) begin
      idx = (unsigned'(32'(rr_q)) + i) % unsigned'(N_REQ);
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = RR_W'(idx);
      end
    end

    do_grant = win_vld & ch_free;

    busy_d  = busy_q;
    alloc_d = alloc_q & ~rel_vld;
    id_d    = id_q;
    rr_d    = rr_q;
    grant_d = '0;
    rel_cnt = '0;

    for (int unsigned r = 0; r < unsigned'(N_REQ); r++) begin
      if (rel_vld[r]) begin
        busy_d[id_q[r*ID_W +: ID_W]] = 1'b0;
        rel_cnt = rel_cnt + CNT_W'(1);
      end
    end

    // The granted channel was free in busy_q, so it never collides with a
    // channel being released in the same cycle.
    if (do_grant) begin
      grant_d[win]             = 1'b1;
      alloc_d[win]             = 1'b1;
      id_d[win*ID_W +: ID_W]   = ch_sel;
      busy_d[ch_sel]           = 1'b1;
      rr_d = (win == RR_W'(N_REQ - 1)) ? '0 : win + RR_W'(1);
    end

    free_cnt_d = free_cnt_q + rel_cnt - CNT_W'(do_grant);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_q     <= '0;
      alloc_q    <= '0;
      id_q       <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      free_cnt_q <= CNT_W'(N_CH);
    end else if (clr_i) begin
      busy_q     <= '0;
      alloc_q    <= '0;
      id_q       <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      free_cnt_q <= CNT_W'(N_CH);
    end else begin
      busy_q     <= busy_d;
      alloc_q    <= alloc_d;
      id_q       <= id_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign alloc_o    = alloc_q;
  assign ch_id_o    = id_q;
  assign ch_busy_o  = busy_q;
  assign free_cnt_o = free_cnt_q;
  assign full_o     = (free_cnt_q == '0);

endmodule

// File: tb/tb_udma_ch_alloc.sv
// tb_udma_ch_alloc: directed self-checking bench for udma_ch_alloc with a
// 4-channel pool shared by 6 requesters.
module tb_udma_ch_alloc;

  localparam int N_CH  = 4;
  localparam int N_REQ = 6;
  localparam int ID_W  = 2;
  localparam int CNT_W = 3;

  logic                  clk_i;
  logic                  rstn_i;
  logic                  clr_i;
  logic [N_REQ-1:0]      req_i;
  logic [N_REQ-1:0]      rel_i;
  logic [N_REQ-1:0]      grant_o;
  logic [N_REQ-1:0]      alloc_o;
  logic [N_REQ*ID_W-1:0] ch_id_o;
  logic [N_CH-1:0]       ch_busy_o;
  logic [CNT_W-1:0]      free_cnt_o;
  logic                  full_o;

  int checks = 0;
  int errors = 0;

  udma_ch_alloc #(
    .N_CH (N_CH),
    .N_REQ(N_REQ)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (clr_i),
    .req_i     (req_i),
    .rel_i     (rel_i),
    .grant_o   (grant_o),
    .alloc_o   (alloc_o),
    .ch_id_o   (ch_id_o),
    .ch_busy_o (ch_busy_o),
    .free_cnt_o(free_cnt_o),
    .full_o    (full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [ID_W-1:0] id_of(input int r);
    return ch_id_o[r*ID_W +: ID_W];
  endfunction

  task automatic check_state(input string tag, input logic [N_REQ-1:0] g,
                             input logic [N_REQ-1:0] a, input logic [N_CH-1:0] b,
                             input logic [CNT_W-1:0] f);
    check({tag, ".grant"}, 32'(grant_o), 32'(g));
    check({tag, ".alloc"}, 32'(alloc_o), 32'(a));
    check({tag, ".busy"},  32'(ch_busy_o), 32'(b));
    check({tag, ".free"},  32'(free_cnt_o), 32'(f));
    check({tag, ".full"},  32'(full_o), 32'(f == 0));
  endtask

  initial begin
    rstn_i = 1'b0;
    clr_i  = 1'b0;
    req_i  = '0;
    rel_i  = '0;
    tick();
    tick();
    check_state("reset", 6'b000000, 6'b000000, 4'b0000, 3'd4);
    check("reset.ids", 32'(ch_id_o), 32'd0);
    rstn_i = 1'b1;
    tick();

    // Single request: granted next cycle with channel 0.
    req_i = 6'b000001;
    tick();
    check_state("single", 6'b000001, 6'b000001, 4'b0001, 3'd3);
    check("single.id0", 32'(id_of(0)), 32'd0);
    req_i = '0;
    tick();
    check("single.pulse", 32'(grant_o), 32'd0);

    // Flush, then all six request; r0..r3 granted in order with IDs 0..3.
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_state("clr1", 6'b000000, 6'b000000, 4'b0000, 3'd4);
    req_i = 6'b111111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d.grant", k), 32'(grant_o), 32'(1 << k));
      check($sformatf("rr%0d.id", k), 32'(id_of(k)), 32'(k));
      check($sformatf("rr%0d.free", k), 32'(free_cnt_o), 32'(3 - k));
      req_i[k] = 1'b0;
    end
    tick();
    check_state("full1", 6'b000000, 6'b001111, 4'b1111, 3'd0);
    tick();
    check("full2.grant", 32'(grant_o), 32'd0);

    // Release r2 while full: r4 gets channel 2 one cycle later.
    rel_i = 6'b000100;
    tick();
    rel_i = '0;
    check_state("rel2", 6'b000000, 6'b001011, 4'b1011, 3'd1);
    tick();
    check_state("r4", 6'b010000, 6'b011011, 4'b1111, 3'd0);
    check("r4.id", 32'(id_of(4)), 32'd2);
    req_i[4] = 1'b0;

    // Release r0 with r5 pending: freed channel not grantable same cycle.
    rel_i = 6'b000001;
    tick();
    rel_i = '0;
    check_state("rel0", 6'b000000, 6'b011010, 4'b1110, 3'd1);
    tick();
    check_state("r5", 6'b100000, 6'b111010, 4'b1111, 3'd0);
    check("r5.id", 32'(id_of(5)), 32'd0);
    req_i[5] = 1'b0;

    // Release from a non-owner and request from an owner: no effect.
    rel_i = 6'b000001;
    req_i = 6'b000010;
    tick();
    rel_i = '0;
    req_i = '0;
    check_state("noop", 6'b000000, 6'b111010, 4'b1111, 3'd0);
    check("noop.id1", 32'(id_of(1)), 32'd1);
    check("noop.id3", 32'(id_of(3)), 32'd3);

    // Flush with r1 requesting: no grant in the flush cycle, then r1 wins
    // channel 0 (RR pointer back at 0).
    clr_i = 1'b1;
    req_i = 6'b000010;
    tick();
    clr_i = 1'b0;
    check_state("clr2", 6'b000000, 6'b000000, 4'b0000, 3'd4);
    check("clr2.ids", 32'(ch_id_o), 32'd0);
    tick();
    check_state("postclr", 6'b000010, 6'b000010, 4'b0001, 3'd3);
    check("postclr.id1", 32'(id_of(1)), 32'd0);

    // Asynchronous reset while r2's grant is pending.
    req_i = 6'b000100;
    #3;
    rstn_i = 1'b0;
    #1;
    check_state("arst", 6'b000000, 6'b000000, 4'b0000, 3'd4);
    tick();
    check("arst.hold", 32'(grant_o), 32'd0);
    req_i = '0;
    rstn_i = 1'b1;
    tick();
    check_state("arst.rel", 6'b000000, 6'b000000, 4'b0000, 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
